output_display_driver: RTL and testbench
========================================

Name: output_display_driver

Overview:
- Downstream consumer of the output memory/port stage's 32-bit `dataout` word.
- On a start strobe, captures the word as a signed two's-complement value and converts its magnitude to BCD with a sequential shift-add-3 (double-dabble) engine.
- Drives NDIGITS active-low 7-segment displays with leading-zero blanking, plus sign and overflow indicators.

Parameters:
- DATA_WIDTH, 32, input word width; conversion takes DATA_WIDTH cycles.
- NDIGITS, 8, number of physical 7-segment digits driven (1..10).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  capture request; sampled only in IDLE.
- datain  input  DATA_WIDTH  word from the output stage's dataout.
- segments  output  7*NDIGITS  active-low segments; digit k occupies bits [7k+6:7k], bit order gfedcba, digit 0 is least significant.
- negative  output  1  registered sign of the last displayed value.
- overflow  output  1  magnitude needs more than NDIGITS decimal digits.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse when outputs update.

Behaviour:
- Reset (async, active-high), from any state including mid-conversion:
  - state=IDLE, all internal registers cleared.
  - segments all 1 (blank).
  - negative=0, overflow=0, busy=0, done=0.
- States are IDLE, CONVERT, FINISH.
- IDLE:
  - If start=1 at edge E0: magnitude = datain[MSB] ? (~datain+1) : datain, treated as unsigned DATA_WIDTH bits, so 0x80000000 gives 2147483648.
  - Latch sign, clear the 40-bit BCD accumulator (10 digits), count=0, go to CONVERT, busy=1.
- CONVERT (edges E1..E_DATA_WIDTH), each cycle:
  - Every BCD nibble >=5 gets +3.
  - Then {bcd, mag} shifts left by 1.
  - count increments.
  - After the shift with count=DATA_WIDTH-1, go to FINISH.
- FINISH (edge E_DATA_WIDTH+1):
  - Register segments, negative and overflow.
  - done=1 for exactly this one cycle; busy=0; return to IDLE.
  - Total latency from start to done is DATA_WIDTH+1 edges (33 for the default).
- Overflow: set if any BCD digit at index >= NDIGITS is nonzero. On overflow every digit shows dash (0111111); negative still reflects the sign.
- Leading-zero blanking:
  - Digits above the most significant nonzero digit show blank (1111111).
  - Digit 0 always shows a numeral, so zero displays "0".
- Encoding, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Display outputs hold their values between conversions. They change only in FINISH or on reset.
- start while busy (CONVERT/FINISH) is ignored, not queued. start held high re-triggers on the first IDLE cycle after FINISH.
- datain changes during CONVERT have no effect, because the operand is captured at E0.
- Negative zero cannot occur; 0 gives negative=0.

Decomposition:
- Shared package `display_pkg` holds:
  - state encoding constants (IDLE, CONVERT, FINISH);
  - SEG_BLANK=7'b1111111, SEG_DASH=7'b0111111;
  - the ten digit encodings;
  - BCD_DIGITS=10.
- One combinational sub-module `bcd_to_seg7` (4-bit BCD in, blank flag in, 7-bit active-low segments out), instantiated NDIGITS times.
- The FSM, the double-dabble datapath and the blanking/overflow logic stay in the top.

Test Plan:
- Reset release, then start with datain=12345 → done exactly 33 edges after start.
  - Digits 0..4 = 0010010, 0011001, 0110000, 0100100, 1111001.
  - Digits 5..7 = 1111111.
  - negative=0, overflow=0.
- datain=0xFFFFFFF9 (-7) → digit0=1111000, all other digits blank, negative=1, overflow=0.
- datain=0 → digit0=1000000, others blank, negative=0.
- datain=100000000, then datain=0x80000000 (NDIGITS=8) → both give all digits 0111111 and overflow=1; negative=0 then 1.
- With 99999999 displayed, start datain=5 and pulse start again at E10 → second pulse ignored, single done pulse, final display "5".
- With 99999999 displayed, start datain=5 and assert reset at E15 → all segments blank, busy=0, no done pulse.

Source files
------------

// File: rtl/display_pkg.sv
// Shared encodings for the output display driver: FSM states and active-low gfedcba glyphs.
// Pure constants; no timing or flow-control behaviour.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        FINISH  = 2'd2
    } state_t;

    localparam int BCD_DIGITS = 10;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

endpackage

// File: rtl/output_display_driver_if.sv
// Start/operand request and display result bundle between the output stage and the display driver.
// The driver has no backpressure: start is only honoured while the driver is idle.
interface output_display_driver_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NDIGITS    = 8
);
    logic                   start;
    logic [DATA_WIDTH-1:0]  datain;
    logic [7*NDIGITS-1:0]   segments;
    logic                   negative;
    logic                   overflow;
    logic                   busy;
    logic                   done;

    modport master (
        output start, datain,
        input  segments, negative, overflow, busy, done
    );

    modport slave (
        input  start, datain,
        output segments, negative, overflow, busy, done
    );
endinterface

// File: rtl/output_display_driver_bcd_to_seg7.sv
// One BCD digit to active-low gfedcba segments; combinational, zero latency.
// Codes above 9 never occur in a valid accumulator and render blank.
module bcd_to_seg7
    import display_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);
    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (bcd_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end
endmodule

// File: rtl/output_display_driver.sv
// Signed word to blanked 7-segment display via sequential double-dabble; done DATA_WIDTH+1 edges after start.
// No queueing: start is ignored while busy, display outputs hold between conversions.
module output_display_driver
    import display_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NDIGITS    = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    output_display_driver_if.slave bus
);
    localparam int CNT_W    = $clog2(DATA_WIDTH);
    localparam int BCD_BITS = 4 * BCD_DIGITS;

    state_t                 state_q, state_d;
    logic                   sign_q, sign_d;
    logic [DATA_WIDTH-1:0]  mag_q, mag_d;
    logic [BCD_BITS-1:0]    bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [7*NDIGITS-1:0]   seg_q, seg_d, seg_num;
    logic                   neg_q, neg_d, ovf_q, ovf_d, done_q, done_d;
    logic                   ovf_c, seen_nz;
    logic [NDIGITS-1:0]     blank_c;

    // Overflow from digits beyond the display; blank every digit above the leading nonzero one.
    always_comb begin
        ovf_c   = 1'b0;
        seen_nz = 1'b0;
        blank_c = '0;
        for (int i = NDIGITS; i < BCD_DIGITS; i++)
            ovf_c = ovf_c | (bcd_q[4*i +: 4] != 4'd0);
        for (int k = NDIGITS - 1; k >= 0; k--) begin
            seen_nz    = seen_nz | (bcd_q[4*k +: 4] != 4'd0);
            blank_c[k] = (k != 0) && !seen_nz;
        end
    end

    for (genvar k = 0; k < NDIGITS; k++) begin : g_digit
        bcd_to_seg7 u_seg (
            .bcd_i   (bcd_q[4*k +: 4]),
            .blank_i (blank_c[k]),
            .seg_o   (seg_num[7*k +: 7])
        );
    end

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        mag_d   = mag_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        seg_d   = seg_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_DIGITS; i++)
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sign_d  = bus.datain[DATA_WIDTH-1];
                    mag_d   = bus.datain[DATA_WIDTH-1] ? (~bus.datain + 1'b1) : bus.datain;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                {bcd_d, mag_d} = {bcd_adj[BCD_BITS-2:0], mag_q, 1'b0};
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_WIDTH - 1))
                    state_d = FINISH;
            end
            FINISH: begin
                seg_d   = ovf_c ? {NDIGITS{SEG_DASH}} : seg_num;
                neg_d   = sign_q;
                ovf_d   = ovf_c;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            mag_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            seg_q   <= '1;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            mag_q   <= mag_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            seg_q   <= seg_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign bus.segments = seg_q;
    assign bus.negative = neg_q;
    assign bus.overflow = ovf_q;
    assign bus.done     = done_q;
    assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_output_display_driver.sv
// Directed bench for output_display_driver with a decimal reference model and result scoreboard.
module tb_output_display_driver;
    localparam int DW = 32;
    localparam int ND = 8;

    typedef struct packed {
        logic [7*ND-1:0] seg;
        logic            neg;
        logic            ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    output_display_driver_if #(.DATA_WIDTH(DW), .NDIGITS(ND)) dif ();

    output_display_driver #(.DATA_WIDTH(DW), .NDIGITS(ND)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (dif)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] v);
        exp_t            e;
        longint unsigned m;
        int              d[10];
        int              msd;
        e.neg = v[31];
        m = v[31] ? (64'd4294967296 - {32'd0, v}) : {32'd0, v};
        for (int i = 0; i < 10; i++) begin
            d[i] = int'(m % 10);
            m    = m / 10;
        end
        e.ovf = (d[8] != 0) || (d[9] != 0);
        msd = 0;
        for (int i = 0; i < 10; i++) if (d[i] != 0) msd = i;
        for (int k = 0; k < ND; k++)
            e.seg[7*k +: 7] = e.ovf ? 7'b0111111 : (k > msd ? 7'b1111111 : glyph(d[k]));
        return e;
    endfunction

    task automatic compare_result(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_segments"}, 64'(dif.segments), 64'(e.seg));
            check({tag, "_negative"}, 64'(dif.negative), 64'(e.neg));
            check({tag, "_overflow"}, 64'(dif.overflow), 64'(e.ovf));
        end
    endtask

    // Returns after E0 has been sampled, with start already dropped.
    task automatic start_conv(input logic [31:0] v, input bit push);
        @(negedge clk);
        dif.datain = v;
        dif.start  = 1'b1;
        if (push) sb.push_back(model(v));
        @(posedge clk);
        #1;
        dif.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (dif.done === 1'b1) break;
        end
        check({tag, "_latency"}, 64'(n), 64'd33);
        check({tag, "_busy_at_done"}, 64'(dif.busy), 64'd0);
        compare_result(tag);
        @(posedge clk);
        #1;
        check({tag, "_done_one_cycle"}, 64'(dif.done), 64'd0);
    endtask

    initial begin
        int dones;
        int done_at;
        rst        = 1'b1;
        dif.start  = 1'b0;
        dif.datain = '0;
        repeat (3) @(negedge clk);
        check("rst_segments", 64'(dif.segments), 64'({7*ND{1'b1}}));
        check("rst_negative", 64'(dif.negative), 64'd0);
        check("rst_overflow", 64'(dif.overflow), 64'd0);
        check("rst_busy", 64'(dif.busy), 64'd0);
        check("rst_done", 64'(dif.done), 64'd0);
        rst = 1'b0;

        start_conv(32'd12345, 1'b1);
        check("busy_after_start", 64'(dif.busy), 64'd1);
        wait_done("d12345");
        start_conv(32'hFFFF_FFF9, 1'b1);
        wait_done("neg7");
        start_conv(32'd0, 1'b1);
        wait_done("zero");
        start_conv(32'd100000000, 1'b1);
        wait_done("ovf_pos");
        start_conv(32'h8000_0000, 1'b1);
        wait_done("ovf_min");

        // Second start mid-conversion and operand change must both be ignored.
        start_conv(32'd99999999, 1'b1);
        wait_done("nines_a");
        start_conv(32'd5, 1'b1);
        dones   = 0;
        done_at = 0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (n == 3) dif.datain = 32'hDEAD_BEEF;
            if (n == 9) dif.start = 1'b1;
            if (n == 10) dif.start = 1'b0;
            if (n == 20) check("busy_mid", 64'(dif.busy), 64'd1);
            if (dif.done === 1'b1) begin
                dones++;
                done_at = n;
                compare_result("restart_ignored");
            end
        end
        check("restart_done_count", 64'(dones), 64'd1);
        check("restart_done_edge", 64'(done_at), 64'd33);

        // Reset mid-conversion aborts with blank display and no done.
        start_conv(32'd99999999, 1'b1);
        wait_done("nines_b");
        start_conv(32'd5, 1'b0);
        for (int n = 1; n <= 14; n++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        check("abort_segments", 64'(dif.segments), 64'({7*ND{1'b1}}));
        check("abort_busy", 64'(dif.busy), 64'd0);
        check("abort_done", 64'(dif.done), 64'd0);
        check("abort_negative", 64'(dif.negative), 64'd0);
        @(negedge clk);
        rst   = 1'b0;
        dones = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (dif.done === 1'b1) dones++;
        end
        check("abort_no_done", 64'(dones), 64'd0);
        check("abort_hold_blank", 64'(dif.segments), 64'({7*ND{1'b1}}));

        start_conv(32'hFFFF_FC2E, 1'b1);
        wait_done("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
